kmeans_argmin_tracker: RTL

Streaming nearest-centroid selector for the K-means assignment stage. It consumes one packet of per-cluster distances, one per beat, each tagged with a cluster index. It keeps a 64-bit running-minimum register whose reset value is all ones, and emits the winning cluster index, its distance and the beat count once per packet. It is the consumer side of the distance registers: it reads distances from the distance datapath and hands assignments to the centroid-update logic.

---
 rtl/kmeans_argmin_tracker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/kmeans_argmin_tracker.sv
// ---------------------------------------------------------------------------
// kmeans_argmin_tracker
//
// Streaming nearest-centroid selector for the K-means assignment stage.
// One packet of per-cluster distances arrives one beat per cycle, each beat
// tagged with its cluster index. The tracker keeps a running minimum and,
// once the last beat has been taken, presents the winning index, its
// distance and the beat count (saturating) until downstream accepts it.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   distance beat valid
//   in_ready   tracker accepts a beat (IDLE/ACCUM, low while reset)
//   in_dist    unsigned distance, DW bits
//   in_idx     cluster index of in_dist, IW bits
//   in_last    final beat of the packet
//   out_valid  result valid (HOLD)
//   out_ready  downstream accepts the result
//   out_idx    index of the minimum distance
//   out_dist   minimum distance
//   out_count  beats in the packet, saturating at 2^CW-1
// ---------------------------------------------------------------------------
module kmeans_argmin_tracker #(
   parameter int DW = 64,
   parameter int IW = 3,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_dist,
   input  logic [IW-1:0] in_idx,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_idx,
   output logic [DW-1:0] out_dist,
   output logic [CW-1:0] out_count
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [DW-1:0] DIST_MAX  = {DW{1'b1}};
   localparam logic [CW-1:0] COUNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [DW-1:0] min_q, min_d;
   logic [IW-1:0] best_q, best_d;
   logic [CW-1:0] count_q, count_d;
   logic [IW-1:0] out_idx_q, out_idx_d;
   logic [DW-1:0] out_dist_q, out_dist_d;
   logic [CW-1:0] out_count_q, out_count_d;
   logic          beat_fire;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      if (&c) return c;
      return c + 1'b1;
   endfunction

   // in_ready is a function of state only, gated low while reset is held.
   assign in_ready  = !reset && (state_q != HOLD);
   assign out_valid = (state_q == HOLD);
   assign out_idx   = out_idx_q;
   assign out_dist  = out_dist_q;
   assign out_count = out_count_q;
   assign beat_fire = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      min_d       = min_q;
      best_d      = best_q;
      count_d     = count_q;
      out_idx_d   = out_idx_q;
      out_dist_d  = out_dist_q;
      out_count_d = out_count_q;
      case (state_q)
         IDLE: begin
            if (beat_fire) begin
               // First beat always loads, so an all-ones packet still
               // reports the first beat's index.
               min_d   = in_dist;
               best_d  = in_idx;
               count_d = COUNT_ONE;
               state_d = in_last ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (beat_fire) begin
               // Strict compare: on ties the earliest beat keeps the win.
               if (in_dist < min_q) begin
                  min_d  = in_dist;
                  best_d = in_idx;
               end
               count_d = sat_inc(count_q);
               if (in_last) state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
               min_d   = DIST_MAX;
               best_d  = '0;
               count_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Result registers capture the packet totals including the last beat.
      if (state_q != HOLD && state_d == HOLD) begin
         out_idx_d   = best_d;
         out_dist_d  = min_d;
         out_count_d = count_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         min_q       <= DIST_MAX;
         best_q      <= '0;
         count_q     <= '0;
         out_idx_q   <= '0;
         out_dist_q  <= DIST_MAX;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         min_q       <= min_d;
         best_q      <= best_d;
         count_q     <= count_d;
         out_idx_q   <= out_idx_d;
         out_dist_q  <= out_dist_d;
         out_count_q <= out_count_d;
      end
   end

endmodule
